// File: rtl/lidar_point_streamer_if.sv
// Point-stream bundle between host loader/clusterer (master) and the streamer (slave).
interface lidar_point_streamer_if #(parameter int ADDR_W = 4);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              start;
  logic [ADDR_W:0]   n_points;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [7:0]        z;
  logic              valid;
  logic              last;
  logic              cl_done;
  logic              busy;
  logic              finish;

  modport master (
    output wr_en, wr_addr, wr_data, start, n_points, cl_done,
    input  x, y, z, valid, last, busy, finish
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, n_points, cl_done,
    output x, y, z, valid, last, busy, finish
  );
endinterface

// File: rtl/lidar_point_streamer.sv
// Replays a host-loaded x/y/z point buffer as a valid/last pulse stream, one point
// every GAP+1 cycles, then waits for the clusterer's done before signalling finish.
module lidar_point_streamer #(
  parameter int ADDR_W = 4,
  parameter int GAP    = 1
) (
  input  logic clk,
  input  logic rst,
  lidar_point_streamer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SEND, HOLD, WAIT_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [23:0]       mem [DEPTH];
  logic [23:0]       rd_data;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n_lat;
  logic [GW-1:0]     gap_cnt;
  logic              start_ok;
  logic              at_last;

  assign start_ok = bus.start && (bus.n_points != '0) &&
                    (bus.n_points <= (ADDR_W+1)'(DEPTH));
  assign at_last  = ({1'b0, idx} == (n_lat - 1'b1));

  // Read runs every cycle on idx; idx is already advanced during HOLD, so the
  // final HOLD cycle doubles as the fetch for the next point.
  always_ff @(posedge clk) begin
    if (bus.wr_en && state == IDLE)
      mem[bus.wr_addr] <= bus.wr_data;
    rd_data <= mem[idx];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = FETCH;
      FETCH:     state_nxt = SEND;
      SEND:      state_nxt = at_last ? WAIT_DONE : HOLD;
      HOLD:      if (gap_cnt == '0) state_nxt = SEND;
      WAIT_DONE: if (bus.cl_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      n_lat      <= '0;
      gap_cnt    <= '0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.z      <= '0;
      bus.valid  <= 1'b0;
      bus.last   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.finish <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus.valid  <= 1'b0;
      bus.last   <= 1'b0;
      bus.finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            n_lat    <= bus.n_points;
            idx      <= '0;
            bus.busy <= 1'b1;
          end
        end
        SEND: begin
          {bus.x, bus.y, bus.z} <= rd_data;
          bus.valid <= 1'b1;
          bus.last  <= at_last;
          gap_cnt   <= GW'(GAP - 1);
          if (!at_last)
            idx <= idx + 1'b1;
        end
        HOLD: begin
          if (gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
        end
        WAIT_DONE: begin
          if (bus.cl_done) begin
            bus.finish <= 1'b1;
            bus.busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
